q_sys_timer_tick_ctrl: RTL and testbench

Q_SYS_TIMER_TICK_CTRL -- requirements
Module: q_sys_timer_tick_ctrl

---
 rtl/q_sys_timer_tick_ctrl.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_q_sys_timer_tick_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/q_sys_timer_tick_ctrl.sv
// q_sys_timer_tick_ctrl
//
// Sequencer that programs and services an interval timer through its s1
// slave port. It loads the period, starts the timer in continuous mode with
// interrupts enabled, acknowledges each timeout interrupt as a tick, and
// stops the timer on request. Optional snapshot support reads the running
// counter back through the timer's snapshot registers.
//
// Build option:
//   TIMER_TICK_CTRL_SNAP_EN  when defined, adds the snapshot states and the
//                            snap_value / snap_valid capture path. When it is
//                            not defined, cfg_snap is ignored and both snapshot
//                            outputs stay 0.
//
// Ports:
//   clk             in   1   sole clock, rising edge
//   reset_n         in   1   synchronous active-low reset
//   cfg_period      in   32  period to program, sampled when cfg_start is accepted
//   cfg_start       in   1   start request pulse (honoured only in IDLE)
//   cfg_stop        in   1   stop request pulse (honoured only in RUN)
//   cfg_snap        in   1   snapshot request pulse (honoured only in RUN)
//   tmr_address     out  3   timer s1 register address
//   tmr_chipselect  out  1   timer s1 chipselect
//   tmr_write_n     out  1   timer s1 active-low write strobe
//   tmr_writedata   out  16  timer s1 write data
//   tmr_readdata    in   16  timer s1 read data, one cycle after address
//   tmr_irq         in   1   timer level interrupt
//   busy            out  1   high in every state except IDLE
//   tick            out  1   one-cycle pulse per serviced interrupt
//   cfg_err         out  1   one-cycle pulse when cfg_start carries period 0
//   tick_count      out  32  serviced interrupts since reset, wraps at 2^32
//   snap_value      out  32  last captured counter snapshot
//   snap_valid      out  1   one-cycle pulse when snap_value is updated
//
// State      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | timer not driven; waiting for cfg_start
// WR_PL      | write period[15:0] to periodl (addr 2)
// WR_PH      | write period[31:16] to periodh (addr 3)
// WR_CTRL    | write ITO|CONT|START to control (addr 1)
// RUN        | timer running; service stop / irq / snap requests
// CLR        | clear timeout flag (addr 0), emit tick
// STOP_CTRL  | write STOP to control (addr 1)
// STOP_CLR   | clear any pending timeout flag (addr 0), then IDLE
// SNAP_WR    | write snapl (addr 4) to latch the counter
// SNAP_RL    | present snapl (addr 4) for read
// SNAP_RH    | present snaph (addr 5), capture low half

module q_sys_timer_tick_ctrl #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd49999
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] cfg_period,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    input  logic        cfg_snap,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic [15:0] tmr_readdata,
    input  logic        tmr_irq,
    output logic        busy,
    output logic        tick,
    output logic        cfg_err,
    output logic [31:0] tick_count,
    output logic [31:0] snap_value,
    output logic        snap_valid
);

    localparam logic [2:0]  ADDR_STATUS = 3'd0;
    localparam logic [2:0]  ADDR_CTRL   = 3'd1;
    localparam logic [2:0]  ADDR_PERL   = 3'd2;
    localparam logic [2:0]  ADDR_PERH   = 3'd3;
    localparam logic [2:0]  ADDR_SNAPL  = 3'd4;
    localparam logic [2:0]  ADDR_SNAPH  = 3'd5;

    localparam logic [15:0] CTRL_RUN    = 16'h0007;  // ITO | CONT | START
    localparam logic [15:0] CTRL_STOP   = 16'h0008;  // STOP

`ifdef TIMER_TICK_CTRL_SNAP_EN
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_PL     = 4'd1,
        WR_PH     = 4'd2,
        WR_CTRL   = 4'd3,
        RUN       = 4'd4,
        CLR       = 4'd5,
        STOP_CTRL = 4'd6,
        STOP_CLR  = 4'd7,
        SNAP_WR   = 4'd8,
        SNAP_RL   = 4'd9,
        SNAP_RH   = 4'd10
    } state_t;
`else
    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        WR_PL     = 4'd1,
        WR_PH     = 4'd2,
        WR_CTRL   = 4'd3,
        RUN       = 4'd4,
        CLR       = 4'd5,
        STOP_CTRL = 4'd6,
        STOP_CLR  = 4'd7
    } state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] period_q, period_d;
    logic [31:0] tick_count_q, tick_count_d;
    logic        cfg_err_q, cfg_err_d;
    logic [31:0] snap_value_q, snap_value_d;
    logic        snap_valid_q, snap_valid_d;
    logic        snap_pend_q, snap_pend_d;

    logic        start_ok;

    assign start_ok = cfg_start && (cfg_period != 32'd0);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= DEFAULT_PERIOD;
            tick_count_q <= 32'd0;
            cfg_err_q    <= 1'b0;
            snap_value_q <= 32'd0;
            snap_valid_q <= 1'b0;
            snap_pend_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            tick_count_q <= tick_count_d;
            cfg_err_q    <= cfg_err_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
            snap_pend_q  <= snap_pend_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) state_d = WR_PL;
            end
            WR_PL:     state_d = WR_PH;
            WR_PH:     state_d = WR_CTRL;
            WR_CTRL:   state_d = RUN;
            RUN: begin
                // Stop wins over a pending irq; that irq is dropped untick'd
                // because STOP_CLR clears the timeout flag anyway.
                if (cfg_stop)     state_d = STOP_CTRL;
                else if (tmr_irq) state_d = CLR;
`ifdef TIMER_TICK_CTRL_SNAP_EN
                else if (cfg_snap) state_d = SNAP_WR;
`endif
            end
            CLR:       state_d = RUN;
            STOP_CTRL: state_d = STOP_CLR;
            STOP_CLR:  state_d = IDLE;
`ifdef TIMER_TICK_CTRL_SNAP_EN
            SNAP_WR:   state_d = SNAP_RL;
            SNAP_RL:   state_d = SNAP_RH;
            SNAP_RH:   state_d = RUN;
`endif
            default:   state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        period_d     = period_q;
        tick_count_d = tick_count_q;
        cfg_err_d    = 1'b0;
        snap_value_d = snap_value_q;
        snap_valid_d = 1'b0;
        snap_pend_d  = 1'b0;

        if (state_q == IDLE) begin
            if (start_ok)  period_d  = cfg_period;
            if (cfg_start && (cfg_period == 32'd0)) cfg_err_d = 1'b1;
        end

        if (state_q == CLR) tick_count_d = tick_count_q + 32'd1;

`ifdef TIMER_TICK_CTRL_SNAP_EN
        // snaph data is registered by the timer, so it arrives in the cycle
        // after SNAP_RH; snap_pend marks that cycle.
        if (state_q == SNAP_RH) begin
            snap_value_d[15:0] = tmr_readdata;
            snap_pend_d        = 1'b1;
        end
        if (snap_pend_q) begin
            snap_value_d[31:16] = tmr_readdata;
            snap_valid_d        = 1'b1;
        end
`endif
    end

`ifndef TIMER_TICK_CTRL_SNAP_EN
    logic unused_snap_inputs;
    assign unused_snap_inputs = ^{cfg_snap, tmr_readdata, snap_pend_q};
`endif

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = 3'd0;
        tmr_writedata  = 16'd0;
        tick           = 1'b0;
        busy           = (state_q != IDLE);

        case (state_q)
            WR_PL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERL;
                tmr_writedata  = period_q[15:0];
            end
            WR_PH: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_PERH;
                tmr_writedata  = period_q[31:16];
            end
            WR_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CTRL;
                tmr_writedata  = CTRL_RUN;
            end
            CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_STATUS;
                tick           = 1'b1;
            end
            STOP_CTRL: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_CTRL;
                tmr_writedata  = CTRL_STOP;
            end
            STOP_CLR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_STATUS;
            end
`ifdef TIMER_TICK_CTRL_SNAP_EN
            SNAP_WR: begin
                tmr_chipselect = 1'b1;
                tmr_write_n    = 1'b0;
                tmr_address    = ADDR_SNAPL;
            end
            SNAP_RL: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAPL;
            end
            SNAP_RH: begin
                tmr_chipselect = 1'b1;
                tmr_address    = ADDR_SNAPH;
            end
`endif
            default: ;
        endcase
    end

    assign cfg_err    = cfg_err_q;
    assign tick_count = tick_count_q;
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_q_sys_timer_tick_ctrl.sv
// Directed bench for q_sys_timer_tick_ctrl. Inputs change and outputs are
// sampled on the falling edge; the timer's registered read port is modelled
// with fixed snapshot contents 1234 (snapl) / ABCD (snaph).
module tb_q_sys_timer_tick_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] cfg_period;
    logic        cfg_start, cfg_stop, cfg_snap;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata = 16'd0;
    logic        tmr_irq;
    logic        busy, tick, cfg_err, snap_valid;
    logic [31:0] tick_count, snap_value;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    q_sys_timer_tick_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cfg_period     (cfg_period),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_snap       (cfg_snap),
        .tmr_address    (tmr_address),
        .tmr_chipselect (tmr_chipselect),
        .tmr_write_n    (tmr_write_n),
        .tmr_writedata  (tmr_writedata),
        .tmr_readdata   (tmr_readdata),
        .tmr_irq        (tmr_irq),
        .busy           (busy),
        .tick           (tick),
        .cfg_err        (cfg_err),
        .tick_count     (tick_count),
        .snap_value     (snap_value),
        .snap_valid     (snap_valid)
    );

    // Timer s1 read port: data registered one cycle after address.
    always_ff @(posedge clk) begin
        if (tmr_chipselect && tmr_address == 3'd4)      tmr_readdata <= 16'h1234;
        else if (tmr_chipselect && tmr_address == 3'd5) tmr_readdata <= 16'hABCD;
        else                                            tmr_readdata <= 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Timer bus as {cs, write_n, addr, data} for compact comparison.
    function automatic logic [31:0] bus();
        return {12'd0, tmr_chipselect, tmr_write_n, 1'b0, tmr_address, tmr_writedata};
    endfunction

    function automatic logic [31:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {12'd0, 1'b1, 1'b0, 1'b0, a, d};
    endfunction

    function automatic logic [31:0] rd(input logic [2:0] a);
        return {12'd0, 1'b1, 1'b1, 1'b0, a, 16'd0};
    endfunction

    localparam logic [31:0] BUS_IDLE = {12'd0, 1'b0, 1'b1, 1'b0, 3'd0, 16'd0};

    task automatic check_reset_values(input string tag);
        check({tag, "_bus"},      bus(),      BUS_IDLE);
        check({tag, "_busy"},     busy,       32'd0);
        check({tag, "_tick"},     tick,       32'd0);
        check({tag, "_cfg_err"},  cfg_err,    32'd0);
        check({tag, "_count"},    tick_count, 32'd0);
        check({tag, "_snap_val"}, snap_value, 32'd0);
        check({tag, "_snap_vld"}, snap_valid, 32'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        cfg_period = 32'd0;
        cfg_start  = 1'b0;
        cfg_stop   = 1'b0;
        cfg_snap   = 1'b0;
        tmr_irq    = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");

        // Program 0x186A0 and start.
        reset_n    = 1'b1;
        cfg_period = 32'h0001_86A0;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("wr_pl",      bus(), wr(3'd2, 16'h86A0));
        check("wr_pl_busy", busy,  32'd1);
        @(negedge clk);
        check("wr_ph",      bus(), wr(3'd3, 16'h0001));
        @(negedge clk);
        check("wr_ctrl",    bus(), wr(3'd1, 16'h0007));
        @(negedge clk);
        check("run_bus",    bus(), BUS_IDLE);
        check("run_busy",   busy,  32'd1);

        // irq held high: each service is one clear write plus one tick.
        tmr_irq = 1'b1;
        @(negedge clk);
        check("clr1_bus",   bus(), wr(3'd0, 16'h0000));
        check("clr1_tick",  tick,  32'd1);
        check("clr1_count", tick_count, 32'd0);
        @(negedge clk);
        check("run1_tick",  tick,  32'd0);
        check("run1_count", tick_count, 32'd1);
        @(negedge clk);
        tmr_irq = 1'b0;
        check("clr2_tick",  tick,  32'd1);
        @(negedge clk);
        check("run2_count", tick_count, 32'd2);

        // Stop and irq together: stop wins, no tick.
        cfg_stop = 1'b1;
        tmr_irq  = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        tmr_irq  = 1'b0;
        check("stop_ctrl",      bus(), wr(3'd1, 16'h0008));
        check("stop_ctrl_tick", tick,  32'd0);
        @(negedge clk);
        check("stop_clr",       bus(), wr(3'd0, 16'h0000));
        check("stop_clr_tick",  tick,  32'd0);
        @(negedge clk);
        check("stopped_busy",   busy,  32'd0);
        check("stopped_bus",    bus(), BUS_IDLE);
        check("stopped_count",  tick_count, 32'd2);

        // Zero period: error pulse, no access.
        cfg_period = 32'd0;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("err_pulse", cfg_err, 32'd1);
        check("err_bus",   bus(),   BUS_IDLE);
        check("err_busy",  busy,    32'd0);
        @(negedge clk);
        check("err_clear", cfg_err, 32'd0);
        check("err_bus2",  bus(),   BUS_IDLE);

        // Restart with period 5; tick_count survives the stop.
        cfg_period = 32'd5;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("wr_pl5", bus(), wr(3'd2, 16'h0005));
        @(negedge clk);
        check("wr_ph5", bus(), wr(3'd3, 16'h0000));
        @(negedge clk);
        @(negedge clk);
        check("run5_count", tick_count, 32'd2);

        // cfg_start in RUN is ignored.
        cfg_period = 32'd7;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        check("ign_start_bus",  bus(), BUS_IDLE);
        check("ign_start_busy", busy,  32'd1);
        check("ign_start_err",  cfg_err, 32'd0);

        // Wrap: preload tick_count to all ones, then service one irq.
        force dut.tick_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.tick_count_q;
        @(negedge clk);
        check("preload", tick_count, 32'hFFFF_FFFF);
        tmr_irq = 1'b1;
        @(negedge clk);
        tmr_irq = 1'b0;
        check("wrap_tick",  tick, 32'd1);
        @(negedge clk);
        check("wrap_count", tick_count, 32'd0);

        // Snapshot.
        cfg_snap = 1'b1;
        @(negedge clk);
        cfg_snap = 1'b0;
`ifdef TIMER_TICK_CTRL_SNAP_EN
        check("snap_wr", bus(), wr(3'd4, 16'h0000));
        @(negedge clk);
        check("snap_rl", bus(), rd(3'd4));
        @(negedge clk);
        check("snap_rh", bus(), rd(3'd5));
        @(negedge clk);
        check("snap_run_bus", bus(), BUS_IDLE);
        check("snap_vld_early", snap_valid, 32'd0);
        @(negedge clk);
        check("snap_vld",   snap_valid, 32'd1);
        check("snap_value", snap_value, 32'hABCD_1234);
        @(negedge clk);
        check("snap_vld_end",  snap_valid, 32'd0);
        check("snap_hold",     snap_value, 32'hABCD_1234);
`else
        check("nosnap_bus",  bus(), BUS_IDLE);
        check("nosnap_busy", busy,  32'd1);
        @(negedge clk);
        check("nosnap_vld",   snap_valid, 32'd0);
        check("nosnap_value", snap_value, 32'd0);
`endif

        // Stop, restart, then reset while in WR_PH.
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("idle_again", busy, 32'd0);
        cfg_period = 32'h0001_86A0;
        cfg_start  = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        @(negedge clk);
        check("rst_wr_ph", bus(), wr(3'd3, 16'h0001));
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_no_ctrl", bus(), BUS_IDLE);
        check("midrst_idle",    busy,  32'd0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
